// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package ifq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } ifq_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// DEPTH-entry FIFO of {pc, instr} with count, push, pop and synchronous flush.
// Push while full is accepted only together with a pop; flush beats both.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  ifq_entry_t    push_entry,
  input  logic          pop,
  output ifq_entry_t    head,
  output logic [CW-1:0] count
);

  ifq_entry_t    mem_q [DEPTH];
  ifq_entry_t    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_en_s;
  logic          rd_en_s;

  assign rd_en_s = pop && (count_q != {CW{1'b0}});
  assign wr_en_s = push && ((count_q < CW'(DEPTH)) || rd_en_s);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next-state for pointers, count and storage.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (wr_en_s) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_en_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '{pc: 32'd0, instr: 32'd0};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: fetch FSM, fetch PC and memory bus on top of ifq_fifo.
// Optional macro IFQ_BYPASS_EN forwards an ack straight to IF when the queue is empty.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  ifq_state_e    state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          ack_s;
  logic          flush_s;
  logic          push_s;
  logic          fifo_pop_s;
  logic          bypass_s;
  logic [CW-1:0] count_s;
  logic [CW-1:0] post_cnt_s;
  logic [31:0]   next_addr_s;
  ifq_entry_t    head_s;

  assign ack_s       = mem_ack && mem_req_q;
  assign next_addr_s = mem_addr_q + PC_STEP;
  assign fifo_pop_s  = instr_ready && (count_s != {CW{1'b0}});
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;

`ifdef IFQ_BYPASS_EN
  assign bypass_s = (count_s == {CW{1'b0}}) && (state_q == WAIT) && ack_s && !redirect_valid;
`else
  assign bypass_s = 1'b0;
`endif

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush_s),
    .push       (push_s),
    .push_entry ('{pc: mem_addr_q, instr: mem_rdata}),
    .pop        (fifo_pop_s),
    .head       (head_s),
    .count      (count_s)
  );

  // Head presentation, with the empty-queue bypass overriding the FIFO head.
  always_comb begin
    if (bypass_s) begin
      instr_valid = 1'b1;
      instr_data  = mem_rdata;
      instr_pc    = mem_addr_q;
    end else begin
      instr_valid = (count_s != {CW{1'b0}});
      instr_data  = head_s.instr;
      instr_pc    = head_s.pc;
    end
  end

  // Fetch FSM next-state; redirect outranks push and pop.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fetch_pc_d = fetch_pc_q;
    flush_s    = 1'b0;
    push_s     = 1'b0;
    post_cnt_s = count_s;
    case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          flush_s    = 1'b1;
          fetch_pc_d = redirect_pc;
          mem_req_d  = 1'b1;
          mem_addr_d = redirect_pc;
          state_d    = WAIT;
        end else if (count_s < CW'(DEPTH)) begin
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
          state_d    = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          flush_s    = 1'b1;
          fetch_pc_d = redirect_pc;
          if (ack_s) begin
            mem_addr_d = redirect_pc;
            state_d    = WAIT;
          end else begin
            state_d = DISCARD;
          end
        end else if (ack_s) begin
          // A bypassed word taken by IF this cycle never enters the FIFO.
          push_s     = !(bypass_s && instr_ready);
          fetch_pc_d = next_addr_s;
          post_cnt_s = count_s + CW'(push_s) - CW'(fifo_pop_s);
          if (post_cnt_s < CW'(DEPTH)) begin
            mem_addr_d = next_addr_s;
            state_d    = WAIT;
          end else begin
            mem_req_d = 1'b0;
            state_d   = IDLE;
          end
        end else begin
          state_d = WAIT;
        end
      end
      DISCARD: begin
        if (redirect_valid) begin
          flush_s    = 1'b1;
          fetch_pc_d = redirect_pc;
          if (ack_s) begin
            mem_addr_d = redirect_pc;
            state_d    = WAIT;
          end else begin
            state_d = DISCARD;
          end
        end else if (ack_s) begin
          mem_addr_d = fetch_pc_q;
          state_d    = WAIT;
        end else begin
          state_d = DISCARD;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // FSM and bus registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

endmodule
